// File: rtl/frame_diff_ctrl.sv
// frame_diff_ctrl
// Frame-level controller for the motion-detection pipeline. It decides per input
// frame whether the frame is stored as the new reference or compared against the
// stored one, latches the difference threshold at frame boundaries, checks the
// input frame size, and counts eroded motion pixels per output frame to raise an alarm.
module frame_diff_ctrl #(
    parameter int         IMG_HDISP     = 640,
    parameter int         IMG_VDISP     = 480,
    parameter int         REF_PERIOD    = 4,
    parameter logic [7:0] DEF_THRESHOLD = 8'd65,
    parameter int         CNT_W         = 19
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_clken,
    input  logic [7:0]       cfg_threshold,
    input  logic             cfg_threshold_wr,
    input  logic [CNT_W-1:0] cfg_alarm_level,
    input  logic             post_frame_vsync,
    input  logic             post_frame_clken,
    input  logic             post_img_Bit,
    output logic [7:0]       diff_threshold,
    output logic             ref_wr_en,
    output logic             ref_rd_en,
    output logic             ref_valid,
    output logic [15:0]      frame_cnt,
    output logic             size_err,
    output logic [CNT_W-1:0] motion_cnt,
    output logic             motion_cnt_vld,
    output logic             motion_alarm
);

    localparam logic [CNT_W-1:0] FRAME_PIX   = CNT_W'(IMG_HDISP * IMG_VDISP);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [3:0]       PERIOD_LAST = 4'(REF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             per_vsync_p1;
    logic             post_vsync_p1;
    logic             per_armed;
    logic             post_armed;
    logic             per_rise;
    logic             per_fall;
    logic             post_rise;
    logic             post_fall;
    logic             post_in_frame;

    logic [3:0]       period_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] mot_cnt;
    logic [7:0]       thr_pending;
    logic             frame_active;
    logic             size_bad;

    // Saturating increment shared by the pixel and motion counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Previous-vsync flags for edge detection; the armed flags suppress a false
    // frame start when reset is released while a vsync is already high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            per_vsync_p1  <= 1'b0;
            post_vsync_p1 <= 1'b0;
            per_armed     <= 1'b0;
            post_armed    <= 1'b0;
        end else begin
            per_vsync_p1  <= per_frame_vsync;
            post_vsync_p1 <= post_frame_vsync;
            if (!per_frame_vsync) begin
                per_armed <= 1'b1;
            end
            if (!post_frame_vsync) begin
                post_armed <= 1'b1;
            end
        end
    end

    assign per_rise  = per_frame_vsync & ~per_vsync_p1 & per_armed;
    assign per_fall  = ~per_frame_vsync & per_vsync_p1;
    assign post_rise = post_frame_vsync & ~post_vsync_p1 & post_armed;
    assign post_fall = ~post_frame_vsync & post_vsync_p1 & post_in_frame;

    assign frame_active = (state == CAPTURE) || (state == COMPARE);
    assign size_bad     = (pix_cnt != FRAME_PIX);

    // Input-side FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision and the zero-latency reference memory enables.
    always_comb begin
        state_nxt = state;
        ref_wr_en = 1'b0;
        ref_rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (per_rise) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                ref_wr_en = per_frame_clken;
                ref_rd_en = per_frame_clken & ref_valid;
                if (per_fall) begin
                    state_nxt = WAIT;
                end
            end
            COMPARE: begin
                ref_rd_en = per_frame_clken;
                if (per_fall) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (per_rise) begin
                    if ((period_cnt == PERIOD_LAST) || !ref_valid) begin
                        state_nxt = CAPTURE;
                    end else begin
                        state_nxt = COMPARE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frames since the last capture: restarts after a capture, advances after each compare.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            period_cnt <= 4'd0;
        end else if (per_fall) begin
            if (state == CAPTURE) begin
                period_cnt <= 4'd0;
            end else if (state == COMPARE) begin
                period_cnt <= period_cnt + 4'd1;
            end
        end
    end

    // Input pixel count, frame-size check and reference validity.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_cnt   <= '0;
            size_err  <= 1'b0;
            ref_valid <= 1'b0;
        end else begin
            size_err <= 1'b0;
            if (per_rise) begin
                pix_cnt <= '0;
            end else if (per_frame_clken) begin
                pix_cnt <= sat_inc(pix_cnt);
            end
            // Only frames the FSM actually tracked are size-checked; a frame cut
            // by reset is not reported.
            if (per_fall && frame_active) begin
                size_err <= size_bad;
                if (state == CAPTURE) begin
                    ref_valid <= ~size_bad;
                end
            end
        end
    end

    // Threshold staging: writes land in the pending register, frame start publishes it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            thr_pending    <= DEF_THRESHOLD;
            diff_threshold <= DEF_THRESHOLD;
        end else begin
            if (cfg_threshold_wr) begin
                thr_pending <= cfg_threshold;
            end
            if (per_rise) begin
                diff_threshold <= thr_pending;
            end
        end
    end

    // Count of input frames started, wrapping.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt <= 16'd0;
        end else if (per_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Motion pixel accumulation over the erosion output frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mot_cnt       <= '0;
            post_in_frame <= 1'b0;
        end else begin
            if (post_rise) begin
                mot_cnt       <= '0;
                post_in_frame <= 1'b1;
            end else begin
                if (post_frame_clken && post_img_Bit) begin
                    mot_cnt <= sat_inc(mot_cnt);
                end
                if (post_fall) begin
                    post_in_frame <= 1'b0;
                end
            end
        end
    end

    // End-of-frame motion report and alarm decision.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            motion_cnt     <= '0;
            motion_cnt_vld <= 1'b0;
            motion_alarm   <= 1'b0;
        end else begin
            motion_cnt_vld <= 1'b0;
            if (post_fall) begin
                motion_cnt     <= mot_cnt;
                motion_cnt_vld <= 1'b1;
                motion_alarm   <= ref_valid & (cfg_alarm_level != '0) &
                                  (mot_cnt >= cfg_alarm_level);
            end
        end
    end

endmodule
